my_rgb_to_yuv422: RTL
=====================

Name: my_rgb_to_yuv422

Overview:
Converts RGB888 video into 8-bit YUV 4:2:2 (Y + interleaved Cb/Cr), using BT.601 studio-range coefficients.
It is the transmit-side counterpart of the 4:2:2-to-RGB receive path. Its output stream feeds that receive path or the DDR/link writer without modification.
Two parts: a 3-stage colour-space pipeline, then a 2-stage chroma decimator. Timing signals are delay-matched through both.

Parameters:
AVG_EN, 1, 1 = Cb/Cr of each pixel pair averaged with round-half-up; 0 = even pixel's chroma used (co-sited drop).
LATENCY, 5, fixed pipeline depth in clk cycles (localparam; not overridable).

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
i_v_sync  in  1  vertical sync, any polarity, passed through
i_h_sync  in  1  horizontal sync, any polarity, passed through
i_de  in  1  active-pixel enable
i_r_8b  in  8  red
i_g_8b  in  8  green
i_b_8b  in  8  blue
o_v_sync  out  1  i_v_sync delayed LATENCY
o_h_sync  out  1  i_h_sync delayed LATENCY
o_de  out  1  i_de delayed LATENCY
y_out  out  8  luma
c_out  out  8  chroma: Cb on even pixels, Cr on odd pixels of each line

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. All registers clear on reset assertion.
- Reset values: every output is 0, every pipeline/delay register is 0, the phase counter is 0.
- Stage 1: register the nine products. Each product is 17-bit signed, from an 8-bit unsigned input times a signed coefficient.
  - Y coefficients: 66, 129, 25.
  - Cb coefficients: -38, -74, 112.
  - Cr coefficients: 112, -94, -18.
- Stage 2: register three 18-bit signed sums, each with +128 rounding added.
- Stage 3: arithmetic shift right by 8, then add offsets (Y +16, Cb/Cr +128), then clamp to 0..255 and register. This gives 4:4:4 Y/Cb/Cr plus a de flag.
- Phase counter:
  - Held at 0 while the stage-3 de is low.
  - Toggles on each stage-3 de-high cycle, so the first active pixel of every line is even (phase 0).
  - Resets on every line regardless of whether the previous line had odd length.
- Stage 4 (pairing): holds the previous pixel's Y, Cb, Cr, de and phase. This gives a one-pixel look-ahead, so pixel 2k is processed while pixel 2k+1 is visible.
- Stage 5 (output), when o_de is high:
  - Even pixel 2k, AVG_EN=1: c_out = (Cb[2k]+Cb[2k+1]+1)>>1, computed at 9 bits.
  - Odd pixel 2k+1, AVG_EN=1: c_out = (Cr[2k]+Cr[2k+1]+1)>>1.
  - AVG_EN=0: even pixel outputs Cb[2k]; odd pixel outputs Cr[2k], which is registered from the even pixel.
  - y_out always equals the pixel's own Y.
- Odd-length line: the final even pixel has no partner (look-ahead de = 0). It outputs its own Cb unaveraged. No Cr is emitted for it.
- Blanking: when o_de is low, y_out = 16 and c_out = 128.
- Latency: input cycle n appears on outputs at cycle n+5. All three sync/de signals are delayed exactly 5 cycles through a shift register.
- No backpressure: the block accepts one pixel per clk, always.
- de gaps inside a line reset the phase, the same as a new line.
- Reset mid-line: outputs go to 0 immediately. After release, the first de-high pixel is treated as even.

Decomposition:
- Shared package holds:
  - Coefficient constants: CY_R/G/B, CCB_R/G/B, CCR_R/G/B.
  - Offsets: Y_OFS=16, C_OFS=128, BLANK_Y=16, BLANK_C=128.
  - LATENCY_CSC=3 and LATENCY_422=2.
- One sub-module, ycbcr444_to_yuv422, contains stages 4–5 and the phase counter.
- The colour-space stages stay inline in the top module.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> all outputs are 0. After release, o_de first rises exactly 5 cycles after i_de.
2. Solid white (255,255,255), 8-pixel line -> y_out=235 and c_out=128 on every pixel. o_h_sync/o_v_sync equal the inputs delayed 5 cycles.
3. Solid black (0,0,0) -> y_out=16, c_out=128.
4. Pair red (255,0,0) then blue (0,0,255), AVG_EN=1:
   - Pixel 0: y=82, c=165.
   - Pixel 1: y=41, c=175.
5. Same pair with AVG_EN=0:
   - Pixel 0: y=82, c=90.
   - Pixel 1: y=41, c=240.
6. Odd-length line (3 pixels: red, blue, red), then a 2-pixel blue line:
   - Pixel 2 of the first line: y=82, c=90.
   - Next line pixel 0: c=240 (Cb, phase reset to 0).
   - Blanking cycles between lines: y=16, c=128.

Source files
------------

// File: rtl/my_rgb_to_yuv422_pkg.sv
// my_rgb_to_yuv422_pkg
// Shared constants, types and arithmetic helpers for the RGB888 -> YUV 4:2:2
// transmit path. BT.601 studio-range coefficients are scaled by 256.
package my_rgb_to_yuv422_pkg;

  // Luma coefficients
  localparam logic signed [8:0] CY_R  =  9'sd66;
  localparam logic signed [8:0] CY_G  =  9'sd129;
  localparam logic signed [8:0] CY_B  =  9'sd25;
  // Cb coefficients
  localparam logic signed [8:0] CCB_R = -9'sd38;
  localparam logic signed [8:0] CCB_G = -9'sd74;
  localparam logic signed [8:0] CCB_B =  9'sd112;
  // Cr coefficients
  localparam logic signed [8:0] CCR_R =  9'sd112;
  localparam logic signed [8:0] CCR_G = -9'sd94;
  localparam logic signed [8:0] CCR_B = -9'sd18;

  localparam logic signed [17:0] Y_OFS   = 18'sd16;
  localparam logic signed [17:0] C_OFS   = 18'sd128;
  localparam logic signed [17:0] RND_OFS = 18'sd128;  // half LSB before >>> 8
  localparam logic [7:0]         BLANK_Y = 8'd16;
  localparam logic [7:0]         BLANK_C = 8'd128;

  localparam int LATENCY_CSC = 3;
  localparam int LATENCY_422 = 2;
  localparam int LATENCY     = LATENCY_CSC + LATENCY_422;

  typedef logic signed [16:0] prod_t;
  typedef logic signed [17:0] sum_t;

  // Unsigned 8-bit sample times signed coefficient; the result always fits 17 bits.
  function automatic prod_t mul_u8(input logic [7:0] pix, input logic signed [8:0] coef);
    prod_t a;
    prod_t c;
    a = prod_t'({9'd0, pix});
    c = prod_t'(coef);
    return a * c;
  endfunction

  function automatic sum_t sum3(input prod_t a, input prod_t b, input prod_t c);
    return sum_t'(a) + sum_t'(b) + sum_t'(c) + RND_OFS;
  endfunction

  function automatic logic [7:0] clamp_u8(input sum_t v);
    if (v < 18'sd0)
      return 8'd0;
    else if (v > 18'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  // Round-half-up mean of two samples, computed at 9 bits so 255+255+1 cannot wrap.
  function automatic logic [7:0] avg_rhu(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction

endpackage

// File: rtl/my_rgb_to_yuv422_if.sv
// my_rgb_to_yuv422_if
// Video bundle for the RGB -> YUV 4:2:2 converter.
//   i_v_sync/i_h_sync/i_de, i_r_8b/i_g_8b/i_b_8b : RGB888 source timing + pixels
//   o_v_sync/o_h_sync/o_de, y_out/c_out          : YUV 4:2:2 stream (Cb even, Cr odd)
// master = video source/sink side, slave = converter side.
interface my_rgb_to_yuv422_if;
  logic       i_v_sync;
  logic       i_h_sync;
  logic       i_de;
  logic [7:0] i_r_8b;
  logic [7:0] i_g_8b;
  logic [7:0] i_b_8b;
  logic       o_v_sync;
  logic       o_h_sync;
  logic       o_de;
  logic [7:0] y_out;
  logic [7:0] c_out;

  modport master (
    output i_v_sync, i_h_sync, i_de, i_r_8b, i_g_8b, i_b_8b,
    input  o_v_sync, o_h_sync, o_de, y_out, c_out
  );

  modport slave (
    input  i_v_sync, i_h_sync, i_de, i_r_8b, i_g_8b, i_b_8b,
    output o_v_sync, o_h_sync, o_de, y_out, c_out
  );
endinterface

// File: rtl/my_rgb_to_yuv422_ycbcr444_to_yuv422.sv
// ycbcr444_to_yuv422
// Chroma decimator: 4:4:4 Y/Cb/Cr -> 4:2:2 Y + interleaved Cb/Cr, two cycles deep.
//   clk, rst_n                 : pixel clock, async active-low reset
//   i_de, i_v_sync, i_h_sync   : timing aligned with i_y/i_cb/i_cr
//   i_y, i_cb, i_cr            : 4:4:4 samples
//   o_de, o_v_sync, o_h_sync   : timing delayed two cycles
//   o_y, o_c                   : luma, chroma (Cb on even pixel, Cr on odd)
module ycbcr444_to_yuv422
  import my_rgb_to_yuv422_pkg::*;
#(
  parameter bit AVG_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_de,
  input  logic       i_v_sync,
  input  logic       i_h_sync,
  input  logic [7:0] i_y,
  input  logic [7:0] i_cb,
  input  logic [7:0] i_cr,
  output logic       o_de,
  output logic       o_v_sync,
  output logic       o_h_sync,
  output logic [7:0] o_y,
  output logic [7:0] o_c
);

  logic       r_phase;
  logic       r_de4;
  logic       r_ph4;
  logic       r_vs4;
  logic       r_hs4;
  logic [7:0] r_y4;
  logic [7:0] r_cb4;
  logic [7:0] r_cr4;
  logic [7:0] r_cr_hold;

  logic       w_pair;
  logic [7:0] w_c_even;
  logic [7:0] w_cr_pair;

  // The pixel on i_* is the look-ahead partner of the pixel held in stage 4.
  // If it is valid while stage 4 holds an even pixel it is the odd pixel of the
  // same pair, because any de gap resets the phase.
  assign w_pair    = AVG_EN && i_de;
  assign w_c_even  = w_pair ? avg_rhu(r_cb4, i_cb) : r_cb4;
  assign w_cr_pair = w_pair ? avg_rhu(r_cr4, i_cr) : r_cr4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= 1'b0;
      r_de4     <= 1'b0;
      r_ph4     <= 1'b0;
      r_vs4     <= 1'b0;
      r_hs4     <= 1'b0;
      r_y4      <= '0;
      r_cb4     <= '0;
      r_cr4     <= '0;
      r_cr_hold <= '0;
      o_de      <= 1'b0;
      o_v_sync  <= 1'b0;
      o_h_sync  <= 1'b0;
      o_y       <= '0;
      o_c       <= '0;
    end else begin
      // First valid pixel after any de-low cycle is even.
      r_phase <= i_de ? ~r_phase : 1'b0;

      r_de4 <= i_de;
      r_ph4 <= r_phase;
      r_vs4 <= i_v_sync;
      r_hs4 <= i_h_sync;
      r_y4  <= i_y;
      r_cb4 <= i_cb;
      r_cr4 <= i_cr;

      o_de     <= r_de4;
      o_v_sync <= r_vs4;
      o_h_sync <= r_hs4;

      if (!r_de4) begin
        o_y <= BLANK_Y;
        o_c <= BLANK_C;
      end else begin
        o_y <= r_y4;
        if (!r_ph4) begin
          o_c       <= w_c_even;
          // Cr for the odd pixel is resolved now, while both pixels are visible.
          r_cr_hold <= w_cr_pair;
        end else begin
          o_c <= r_cr_hold;
        end
      end
    end
  end

endmodule

// File: rtl/my_rgb_to_yuv422.sv
// my_rgb_to_yuv422
// RGB888 -> 8-bit YUV 4:2:2 (BT.601 studio range), fixed 5-cycle latency.
// Three colour-space stages inline, then the 2-stage chroma decimator.
//   clk, rst_n : pixel clock, async active-low reset
//   vif        : slave side of the video bundle (RGB in, Y/C out)
module my_rgb_to_yuv422
  import my_rgb_to_yuv422_pkg::*;
#(
  parameter bit AVG_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  my_rgb_to_yuv422_if.slave   vif
);

  prod_t r_py [3];
  prod_t r_pb [3];
  prod_t r_pr [3];

  sum_t r_sum_y;
  sum_t r_sum_cb;
  sum_t r_sum_cr;

  logic [7:0] r_y3;
  logic [7:0] r_cb3;
  logic [7:0] r_cr3;

  logic [LATENCY_CSC-1:0] r_de_d;
  logic [LATENCY_CSC-1:0] r_vs_d;
  logic [LATENCY_CSC-1:0] r_hs_d;

  logic       w_de_out;
  logic       w_vs_out;
  logic       w_hs_out;
  logic [7:0] w_y_out;
  logic [7:0] w_c_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_py[i] <= '0;
        r_pb[i] <= '0;
        r_pr[i] <= '0;
      end
      r_sum_y  <= '0;
      r_sum_cb <= '0;
      r_sum_cr <= '0;
      r_y3     <= '0;
      r_cb3    <= '0;
      r_cr3    <= '0;
      r_de_d   <= '0;
      r_vs_d   <= '0;
      r_hs_d   <= '0;
    end else begin
      r_py[0] <= mul_u8(vif.i_r_8b, CY_R);
      r_py[1] <= mul_u8(vif.i_g_8b, CY_G);
      r_py[2] <= mul_u8(vif.i_b_8b, CY_B);
      r_pb[0] <= mul_u8(vif.i_r_8b, CCB_R);
      r_pb[1] <= mul_u8(vif.i_g_8b, CCB_G);
      r_pb[2] <= mul_u8(vif.i_b_8b, CCB_B);
      r_pr[0] <= mul_u8(vif.i_r_8b, CCR_R);
      r_pr[1] <= mul_u8(vif.i_g_8b, CCR_G);
      r_pr[2] <= mul_u8(vif.i_b_8b, CCR_B);

      r_sum_y  <= sum3(r_py[0], r_py[1], r_py[2]);
      r_sum_cb <= sum3(r_pb[0], r_pb[1], r_pb[2]);
      r_sum_cr <= sum3(r_pr[0], r_pr[1], r_pr[2]);

      // Arithmetic shift keeps negative chroma sums floored before the offset.
      r_y3  <= clamp_u8((r_sum_y  >>> 8) + Y_OFS);
      r_cb3 <= clamp_u8((r_sum_cb >>> 8) + C_OFS);
      r_cr3 <= clamp_u8((r_sum_cr >>> 8) + C_OFS);

      r_de_d <= {r_de_d[LATENCY_CSC-2:0], vif.i_de};
      r_vs_d <= {r_vs_d[LATENCY_CSC-2:0], vif.i_v_sync};
      r_hs_d <= {r_hs_d[LATENCY_CSC-2:0], vif.i_h_sync};
    end
  end

  ycbcr444_to_yuv422 #(
    .AVG_EN (AVG_EN)
  ) u_422 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_de     (r_de_d[LATENCY_CSC-1]),
    .i_v_sync (r_vs_d[LATENCY_CSC-1]),
    .i_h_sync (r_hs_d[LATENCY_CSC-1]),
    .i_y      (r_y3),
    .i_cb     (r_cb3),
    .i_cr     (r_cr3),
    .o_de     (w_de_out),
    .o_v_sync (w_vs_out),
    .o_h_sync (w_hs_out),
    .o_y      (w_y_out),
    .o_c      (w_c_out)
  );

  assign vif.o_de     = w_de_out;
  assign vif.o_v_sync = w_vs_out;
  assign vif.o_h_sync = w_hs_out;
  assign vif.y_out    = w_y_out;
  assign vif.c_out    = w_c_out;

endmodule
